// File: rtl/ac_bank.sv
// Bank of R independent N-bit accumulators with per-register inc/dec/clear,
// bus and ALU loads, sticky wrap flags and a registered, decoded bus read port.
module ac_bank #(
  parameter int unsigned N         = 16,
  parameter int unsigned R         = 4,
  parameter logic [3:0]  READ_BASE = 4'd8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_en,
  input  logic [$clog2(R)-1:0] wsel,
  input  logic [N-1:0]         datain,
  input  logic                 alu_to_ac,
  input  logic [N-1:0]         alu_out,
  input  logic                 inc_en,
  input  logic                 dec_en,
  input  logic                 clr_en,
  input  logic [$clog2(R)-1:0] asel,
  input  logic [3:0]           read_en,
  output logic [N-1:0]         dataout,
  output logic [N-1:0]         bus_out,
  output logic                 bus_hit,
  output logic [R-1:0]         zero,
  output logic [R-1:0]         wrap
);

  localparam int unsigned SelW = $clog2(R);
  localparam logic [N-1:0] One = N'(1);

  if (N < 2) begin : g_bad_width
    $error("ac_bank: N must be at least 2");
  end
  if (R < 2 || R > 8) begin : g_bad_count
    $error("ac_bank: R must be in 2..8");
  end
  if (32'(READ_BASE) + R > 16) begin : g_bad_base
    $error("ac_bank: READ_BASE + R exceeds the read_en code space");
  end

  logic [N-1:0] reg_q [R];
  logic [N-1:0] reg_d [R];
  logic [R-1:0] wrap_q, wrap_d;
  logic [N-1:0] bus_q, bus_d;
  logic         hit_q, hit_d;

  // Per-register next state: clear > bus write > ALU load > inc/dec.
  // Selects >= R never match any r, so they fall through as no-ops.
  always_comb begin
    for (int unsigned r = 0; r < R; r++) begin
      reg_d[r]  = reg_q[r];
      wrap_d[r] = wrap_q[r];
      if (clr_en && asel == SelW'(r)) begin
        reg_d[r]  = '0;
        wrap_d[r] = 1'b0;
      end else if (write_en && wsel == SelW'(r)) begin
        reg_d[r] = datain;
      end else if (asel == SelW'(r)) begin
        if (alu_to_ac) begin
          reg_d[r] = alu_out;
        end else if (inc_en && !dec_en) begin
          reg_d[r] = reg_q[r] + One;
          if (&reg_q[r]) wrap_d[r] = 1'b1;
        end else if (dec_en && !inc_en) begin
          reg_d[r] = reg_q[r] - One;
          if (reg_q[r] == '0) wrap_d[r] = 1'b1;
        end
      end
    end
  end

  // Bus read samples pre-update register values.
  always_comb begin
    bus_d = '0;
    hit_d = 1'b0;
    for (int unsigned r = 0; r < R; r++) begin
      if (read_en == 4'(32'(READ_BASE) + r)) begin
        bus_d = reg_q[r];
        hit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < R; r++) begin
        reg_q[r] <= '0;
      end
      wrap_q <= '0;
      bus_q  <= '0;
      hit_q  <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < R; r++) begin
        reg_q[r] <= reg_d[r];
      end
      wrap_q <= wrap_d;
      bus_q  <= bus_d;
      hit_q  <= hit_d;
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < R; r++) begin
      zero[r] = (reg_q[r] == '0);
    end
  end

  assign dataout = reg_q[0];
  assign bus_out = bus_q;
  assign bus_hit = hit_q;
  assign wrap    = wrap_q;

endmodule

// File: doc/ac_bank.md
# ac_bank

Parametrised accumulator bank for the datapath: the next generation of the single accumulator, holding R independent N-bit registers. Each register supports bus load, ALU load, increment, decrement and clear. Register 0 feeds the ALU directly. Any register can be placed on the bus through a decoded `read_en` code with one-cycle registered latency. Per-register wrap and zero flags drive loop and branch decisions in the controller.

## Interface
- `N`, 16: register width in bits; ≥ 2.
- `R`, 4: number of registers; 2..8.
- `READ_BASE`, 4'd8: `read_en` code of register 0; register r answers code `READ_BASE + r`; READ_BASE + R ≤ 16 (elaboration-time check).
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `write_en`  in  1: load `datain` into register `wsel`.
- `wsel`  in  $clog2(R): target of `write_en`.
- `datain`  in  N: value from the bus.
- `alu_to_ac`  in  1: load `alu_out` into register `asel`.
- `alu_out`  in  N: ALU result.
- `inc_en`  in  1: increment register `asel`.
- `dec_en`  in  1: decrement register `asel`.
- `clr_en`  in  1: clear register `asel` and its wrap flag.
- `asel`  in  $clog2(R): target of `alu_to_ac`, `inc_en`, `dec_en` and `clr_en`.
- `read_en`  in  4: bus read code.
- `dataout`  out  N: register 0, combinational from the register; feeds the ALU.
- `bus_out`  out  N: registered bus read data.
- `bus_hit`  out  1: registered; high when `bus_out` holds a valid register read.
- `zero`  out  R: bit r high when register r == 0; combinational.
- `wrap`  out  R: sticky bit r, set when register r wraps on inc or dec.

## Operation
- Each register resolves its next value independently. Only enables whose select matches the register apply.
- Priority, highest first:
  - `clr_en` gives 0.
  - `write_en` gives `datain`.
  - `alu_to_ac` gives `alu_out`.
  - `inc_en` and `dec_en`: inc gives +1 mod 2^N, dec gives −1 mod 2^N; both together give no change.
- When `wsel != asel`, a write and an asel-side operation both take effect in the same cycle, each on its own register.
- A higher-priority operation suppresses lower ones on the same register. A suppressed inc or dec does not set `wrap`.
- Wrap flag behaviour:
  - Set by an applied inc from all-ones to 0, or an applied dec from 0 to all-ones.
  - Cleared only by `clr_en` on that register or by reset.
  - `write_en` and `alu_to_ac` leave it unchanged.
  - When a clear and a wrap coincide, the clear wins (the inc is suppressed anyway).
- Select values ≥ R: the enable has no effect on any register and no flag changes.
- Bus read:
  - When `read_en` is in `[READ_BASE, READ_BASE+R)`, `bus_out` takes the register's current (pre-update) value on the next edge, and `bus_hit` goes to 1.
  - Otherwise `bus_out` goes to 0 and `bus_hit` to 0.
- `read_en` is independent of all write-side enables.

## Timing
- Reset (async assert, released synchronously by the system): all registers 0, `wrap` all 0, `bus_out` 0, `bus_hit` 0. Consequently `zero` is all ones and `dataout` is 0.
- Reset asserted mid-cycle overrides every pending operation immediately. No operation completes on the edge where `rst` is high.
- Register updates are visible on `dataout` and `zero` in the cycle after the enabling edge (1-cycle latency).
- Bus read latency is 1 cycle: the code sampled on edge k produces `bus_out`/`bus_hit` valid after edge k, held until edge k+1.
- A read and a write of the same register on the same edge returns the old value. The new value is returned by a read issued one cycle later.
- `wrap` updates on the same edge as the register.
- No multi-cycle operations and no stalls; every enable is single-cycle and may be asserted back-to-back.

## Test plan
- Reset then read: assert `rst`, release, `read_en`=8 → next cycle `bus_out`=0, `bus_hit`=1, `zero`=4'b1111, `wrap`=0.
- Load and read back:
  - `write_en`, `wsel`=2, `datain`=16'h1234, then `read_en`=10 → `bus_out`=16'h1234.
  - `read_en`=12 → `bus_hit`=0, `bus_out`=0.
- Wrap:
  - reg1=16'hFFFF, `inc_en`, `asel`=1 → reg1=0, `zero[1]`=1, `wrap[1]`=1.
  - `dec_en` → reg1=16'hFFFF, `wrap[1]` stays 1.
  - `clr_en` → reg1=0, `wrap[1]`=0.
- Priority:
  - reg0=5 with `clr_en`, `alu_to_ac` (`alu_out`=9) and `inc_en` on `asel`=0 → reg0=0.
  - Repeat without clr → 9.
  - `inc_en` and `dec_en` together on 9 → 9.
- Parallel targets: `write_en` `wsel`=3 `datain`=7 with `alu_to_ac` `asel`=0 `alu_out`=16'hAAAA → reg3=7, `dataout`=16'hAAAA. With `wsel`=`asel`=0 → reg0=7.
- Async reset mid-operation: reg2=3 and `inc_en` held, assert `rst` between edges → registers 0 immediately, no increment on the following edge; `bus_hit` 0.
